pulse_detector: RTL and testbench

Upstream neighbour of the pulse FIFO. Consumes the raw ADC sample stream and detects pulses using a two-threshold hysteresis comparator. For each detected pulse it measures the peak amplitude and the length in samples. It emits one record per pulse on an AXI4-Stream master that feeds the FIFO's slave port.

---
 rtl/pulse_detector.sv | 131 +++++++++++++
 tb/tb_pulse_detector.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_detector.sv
// Hysteresis pulse detector: measures peak and length of each pulse and emits one AXI4-Stream record per pulse.
// Optional macro PULSE_TIMESTAMP_EN prepends the start-beat timestamp to each record.
module pulse_detector #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16,
  parameter int TS_WIDTH  = 32
`ifdef PULSE_TIMESTAMP_EN
  , localparam int TS_BITS = TS_WIDTH
`else
  , localparam int TS_BITS = 0 * TS_WIDTH
`endif
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic [WIDTH-1:0]                     threshold_high,
  input  logic [WIDTH-1:0]                     threshold_low,
  input  logic                                 s_tvalid,
  output logic                                 s_tready,
  input  logic [WIDTH-1:0]                     s_tdata,
  output logic                                 m_tvalid,
  input  logic                                 m_tready,
  output logic [TS_BITS+WIDTH+CNT_WIDTH-1:0]   m_tdata,
  output logic [15:0]                          drop_count,
  output logic                                 busy
);

  typedef enum logic [1:0] {IDLE, ARMED, IN_PULSE} state_t;

  state_t state_reg, state_next;
  logic signed [WIDTH-1:0] sample, thr_hi, thr_lo;
  logic signed [WIDTH-1:0] peak_reg, peak_next;
  logic [CNT_WIDTH-1:0]    length_reg, length_next;
  logic                    above_high, below_low;
  logic                    rec_gen;
  logic [TS_BITS+WIDTH+CNT_WIDTH-1:0] rec_data;

  assign sample     = s_tdata;
  assign thr_hi     = threshold_high;
  assign thr_lo     = threshold_low;
  assign above_high = (sample >= thr_hi);
  assign below_low  = (sample < thr_lo);
  assign s_tready   = 1'b1;
  assign busy       = (state_reg == IN_PULSE);

  always_comb begin
    state_next  = state_reg;
    peak_next   = peak_reg;
    length_next = length_reg;
    rec_gen     = 1'b0;
    if (!enable) begin
      state_next = IDLE;
    end else if (s_tvalid) begin
      case (state_reg)
        IDLE: begin
          if (below_low) state_next = ARMED;
        end
        ARMED: begin
          if (above_high) begin
            state_next  = IN_PULSE;
            peak_next   = sample;
            length_next = CNT_WIDTH'(1);
          end
        end
        IN_PULSE: begin
          // The terminating sample contributes to neither peak nor length.
          if (below_low) begin
            rec_gen    = 1'b1;
            state_next = ARMED;
          end else begin
            if (length_reg != '1) length_next = length_reg + 1'b1;
            if (sample > peak_reg) peak_next = sample;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      peak_reg   <= '0;
      length_reg <= '0;
    end else begin
      state_reg  <= state_next;
      peak_reg   <= peak_next;
      length_reg <= length_next;
    end
  end

`ifdef PULSE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_reg, ts_start_reg;
  logic                pulse_start;

  assign pulse_start = enable & s_tvalid & (state_reg == ARMED) & above_high;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_reg       <= '0;
      ts_start_reg <= '0;
    end else begin
      if (s_tvalid)    ts_reg       <= ts_reg + 1'b1;
      if (pulse_start) ts_start_reg <= ts_reg;
    end
  end

  assign rec_data = {ts_start_reg, peak_reg, length_reg};
`else
  assign rec_data = {peak_reg, length_reg};
`endif

  // Single-entry output register; a record arriving while it is full and not draining is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_tvalid   <= 1'b0;
      m_tdata    <= '0;
      drop_count <= '0;
    end else if (rec_gen) begin
      if (!m_tvalid || m_tready) begin
        m_tvalid <= 1'b1;
        m_tdata  <= rec_data;
      end else if (drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
    end else if (m_tvalid && m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_detector.sv
// Self-checking bench for pulse_detector: directed scenarios plus randomized traffic against a sample-list model.
module tb_pulse_detector;

`ifdef PULSE_TIMESTAMP_EN
  localparam int TSB = 32;
`else
  localparam int TSB = 0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b1;
  logic [15:0]       threshold_high = 16'd100;
  logic [15:0]       threshold_low = 16'd50;
  logic              s_tvalid = 1'b0;
  logic [15:0]       s_tdata = '0;
  logic              m_tready = 1'b1;
  logic              s_tready, m_tvalid, busy;
  logic [TSB+31:0]   m_tdata;
  logic [15:0]       drop_count;
  logic              s_tready4, m_tvalid4, busy4;
  logic [TSB+19:0]   m_tdata4;
  logic [15:0]       drop_count4;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  bit          mdl_armed;
  int          mdl_q[$];
  logic [31:0] mdl_ts, mdl_pulse_ts;
  bit          exp_valid;
  int          exp_peak, exp_len, exp_drop;
  logic [31:0] exp_ts;
  int          hi_v = 100, lo_v = 50;

  always #5 clk = ~clk;

  pulse_detector dut (
    .clk(clk), .reset(reset), .enable(enable),
    .threshold_high(threshold_high), .threshold_low(threshold_low),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .drop_count(drop_count), .busy(busy)
  );

  pulse_detector #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable),
    .threshold_high(threshold_high), .threshold_low(threshold_low),
    .s_tvalid(s_tvalid), .s_tready(s_tready4), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid4), .m_tready(m_tready), .m_tdata(m_tdata4),
    .drop_count(drop_count4), .busy(busy4)
  );

  task automatic model_reset();
    mdl_armed = 0;
    mdl_q.delete();
    mdl_ts = '0;
    mdl_pulse_ts = '0;
    exp_valid = 0;
    exp_peak = 0;
    exp_len = 0;
    exp_ts = '0;
    exp_drop = 0;
  endtask

  // One clock edge of the specification's rules, using the inputs present before the edge.
  task automatic model_step();
    bit consumed, gen;
    int smp, gp, gl;
    consumed = exp_valid && m_tready;
    gen = 0;
    gp = 0;
    gl = 0;
    smp = int'($signed(s_tdata));
    if (!enable) begin
      mdl_armed = 0;
      mdl_q.delete();
    end else if (s_tvalid) begin
      if (mdl_q.size() > 0) begin
        if (smp < lo_v) begin
          gen = 1;
          gl = mdl_q.size();
          gp = mdl_q[0];
          foreach (mdl_q[k]) if (mdl_q[k] > gp) gp = mdl_q[k];
          mdl_q.delete();
          mdl_armed = 1;
        end else begin
          mdl_q.push_back(smp);
        end
      end else if (mdl_armed) begin
        if (smp >= hi_v) begin
          mdl_q.push_back(smp);
          mdl_pulse_ts = mdl_ts;
        end
      end else if (smp < lo_v) begin
        mdl_armed = 1;
      end
    end
    if (s_tvalid) mdl_ts = mdl_ts + 32'd1;
    if (gen) begin
      if (!exp_valid || consumed) begin
        exp_valid = 1;
        exp_peak = gp;
        exp_len = gl;
        exp_ts = mdl_pulse_ts;
      end else if (exp_drop < 65535) begin
        exp_drop++;
      end
    end else if (consumed) begin
      exp_valid = 0;
    end
  endtask

  task automatic set_thr(input int hi, input int lo);
    hi_v = hi;
    lo_v = lo;
    threshold_high = 16'(hi);
    threshold_low = 16'(lo);
  endtask

  task automatic cycle(input bit v, input int d);
    s_tvalid = v;
    s_tdata = 16'(d);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b1;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    set_thr(100, 50);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (m_tvalid !== 1'b0 || busy !== 1'b0 || drop_count !== 16'd0 || m_tdata !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%0b busy=%0b drop=%0d data=%h, want 0/0/0/0", m_tvalid, busy, drop_count, m_tdata);
    end
    n_cmp++;
    if (s_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_tready: got %0b want 1", s_tready);
    end
  endtask

  task automatic test_basic();
    int beats[6] = '{0, 0, 120, 200, 150, 40};
    logic [31:0] want = {16'd200, 16'd3};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1, beats[i]);
      if (i < 5) begin
        n_cmp++;
        if (m_tvalid !== 1'b0) begin
          n_fail++;
          $display("FAIL basic_early_valid beat %0d: got %0b want 0", i, m_tvalid);
        end
      end
      if (i == 4) begin
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %0b want 1", busy); end
      end
    end
    n_cmp++;
    if (m_tvalid !== 1'b1 || m_tdata[31:0] !== want || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_record: got valid=%0b data=%h busy=%0b want 1/%h/0", m_tvalid, m_tdata[31:0], busy, want);
    end
    cycle(0, 0);
    n_cmp++;
    if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle: got %0b want 0", m_tvalid); end
  endtask

  task automatic test_arming();
    int beats[7] = '{120, 130, 40, 120, 80, 60, 30};
    int nrec = 0;
    logic [31:0] got = '0;
    logic [31:0] want = {16'd120, 16'd3};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(i < 7, (i < 7) ? beats[i] : 0);
      if (m_tvalid) begin nrec++; got = m_tdata[31:0]; end
    end
    n_cmp++;
    if (nrec != 1 || got !== want) begin
      n_fail++;
      $display("FAIL arming_records: got count=%0d data=%h want 1/%h", nrec, got, want);
    end
  endtask

  task automatic test_backpressure();
    int beats[5] = '{0, 200, 10, 300, 10};
    logic [31:0] want = {16'd200, 16'd1};
    do_reset();
    m_tready = 1'b0;
    foreach (beats[i]) cycle(1, beats[i]);
    cycle(0, 0);
    n_cmp++;
    if (m_tvalid !== 1'b1 || m_tdata[31:0] !== want || drop_count !== 16'd1 || drop_count4 !== 16'd1) begin
      n_fail++;
      $display("FAIL bp_hold: got valid=%0b data=%h drop=%0d drop4=%0d want 1/%h/1/1", m_tvalid, m_tdata[31:0], drop_count, drop_count4, want);
    end
    m_tready = 1'b1;
    cycle(0, 0);
    n_cmp++;
    if (m_tvalid !== 1'b0 || drop_count !== 16'd1) begin
      n_fail++;
      $display("FAIL bp_release: got valid=%0b drop=%0d want 0/1", m_tvalid, drop_count);
    end
  endtask

  task automatic test_simultaneous();
    int beats[5] = '{0, 200, 10, 250, 260};
    bit dropped_low = 0;
    logic [31:0] want = {16'd260, 16'd2};
    do_reset();
    m_tready = 1'b0;
    foreach (beats[i]) begin
      cycle(1, beats[i]);
      if (i >= 2 && m_tvalid !== 1'b1) dropped_low = 1;
    end
    m_tready = 1'b1;
    cycle(1, 10);
    n_cmp++;
    if (dropped_low || m_tvalid !== 1'b1 || m_tdata[31:0] !== want || drop_count !== 16'd0) begin
      n_fail++;
      $display("FAIL simul_load: got lowgap=%0b valid=%0b data=%h drop=%0d want 0/1/%h/0", dropped_low, m_tvalid, m_tdata[31:0], drop_count, want);
    end
    cycle(0, 0);
    n_cmp++;
    if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL simul_drain: got %0b want 0", m_tvalid); end
  endtask

  task automatic test_gaps();
    logic [31:0] want16 = {16'd119, 16'd20};
    logic [19:0] want4 = {16'd119, 4'd15};
    do_reset();
    cycle(1, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(1, 100 + i);
      cycle(0, -500);
    end
    n_cmp++;
    if (busy !== 1'b1 || m_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL gaps_open: got busy=%0b valid=%0b want 1/0", busy, m_tvalid);
    end
    cycle(1, 0);
    n_cmp++;
    if (m_tvalid !== 1'b1 || m_tdata[31:0] !== want16) begin
      n_fail++;
      $display("FAIL gaps_len: got valid=%0b data=%h want 1/%h", m_tvalid, m_tdata[31:0], want16);
    end
    n_cmp++;
    if (m_tvalid4 !== 1'b1 || m_tdata4[19:0] !== want4) begin
      n_fail++;
      $display("FAIL gaps_sat4: got valid=%0b data=%h want 1/%h", m_tvalid4, m_tdata4[19:0], want4);
    end
  endtask

  task automatic test_abort();
    logic [31:0] want = {16'd200, 16'd1};
    do_reset();
    cycle(1, 0);
    cycle(1, 150);
    cycle(1, 160);
    enable = 1'b0;
    cycle(1, 170);
    n_cmp++;
    if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%0b valid=%0b want 0/0", busy, m_tvalid);
    end
    enable = 1'b1;
    cycle(1, 180);
    cycle(1, 10);
    n_cmp++;
    if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_rearm: got busy=%0b valid=%0b want 0/0", busy, m_tvalid);
    end
    cycle(1, 200);
    cycle(1, 0);
    n_cmp++;
    if (m_tvalid !== 1'b1 || m_tdata[31:0] !== want) begin
      n_fail++;
      $display("FAIL abort_after: got valid=%0b data=%h want 1/%h", m_tvalid, m_tdata[31:0], want);
    end
  endtask

  task automatic test_async_reset();
    int beats[6] = '{0, 200, 10, 210, 10, 220};
    do_reset();
    m_tready = 1'b0;
    foreach (beats[i]) cycle(1, beats[i]);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (m_tvalid !== 1'b0 || drop_count !== 16'd0 || busy !== 1'b0 || m_tdata !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%0b drop=%0d busy=%0b data=%h want 0/0/0/0", m_tvalid, drop_count, busy, m_tdata);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    m_tready = 1'b1;
  endtask

  task automatic test_random();
    logic [TSB+31:0] e16;
    logic [TSB+19:0] e4;
    int l16, l4;
    do_reset();
    for (int seg = 0; seg < 4; seg++) begin
      int lo, hi;
      lo = int'($urandom_range(0, 80)) - 40;
      hi = lo + int'($urandom_range(0, 120));
      if (seg == 3) set_thr(lo, hi); else set_thr(hi, lo);
      for (int c = 0; c < 150; c++) begin
        enable = ($urandom_range(0, 60) != 0);
        m_tready = ($urandom_range(0, 2) != 0);
        cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 400)) - 200);
        l16 = (exp_len > 65535) ? 65535 : exp_len;
        l4 = (exp_len > 15) ? 15 : exp_len;
`ifdef PULSE_TIMESTAMP_EN
        e16 = {exp_ts, 16'(exp_peak), 16'(l16)};
        e4 = {exp_ts, 16'(exp_peak), 4'(l4)};
`else
        e16 = {16'(exp_peak), 16'(l16)};
        e4 = {16'(exp_peak), 4'(l4)};
`endif
        n_cmp++;
        if (m_tvalid !== exp_valid || m_tvalid4 !== exp_valid) begin
          n_fail++;
          $display("FAIL rand_valid seg %0d cyc %0d: got %0b/%0b want %0b", seg, c, m_tvalid, m_tvalid4, exp_valid);
        end
        n_cmp++;
        if (busy !== (mdl_q.size() > 0) || busy4 !== (mdl_q.size() > 0)) begin
          n_fail++;
          $display("FAIL rand_busy seg %0d cyc %0d: got %0b/%0b want %0b", seg, c, busy, busy4, mdl_q.size() > 0);
        end
        n_cmp++;
        if (drop_count !== 16'(exp_drop) || drop_count4 !== 16'(exp_drop)) begin
          n_fail++;
          $display("FAIL rand_drop seg %0d cyc %0d: got %0d/%0d want %0d", seg, c, drop_count, drop_count4, exp_drop);
        end
        if (exp_valid) begin
          n_cmp++;
          if (m_tdata !== e16 || m_tdata4 !== e4) begin
            n_fail++;
            $display("FAIL rand_data seg %0d cyc %0d: got %h/%h want %h/%h", seg, c, m_tdata, m_tdata4, e16, e4);
          end
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_arming();
    test_backpressure();
    test_simultaneous();
    test_gaps();
    test_abort();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
